alu_seq_exec: RTL and testbench

//  Execution unit that consumes the 4-bit ALU control code from the ALU controller, plus two operands.

---
 rtl/alu_seq_exec.sv | 160 ++++++++++++++++
 tb/tb_alu_seq_exec.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_exec.sv
// EX-stage execution unit: single-cycle logic/arithmetic ops and an iterative
// shift-add multiply that stalls the pipeline through busy_o.
module alu_seq_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             overflow_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             ovf_q;
    logic             done_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic signed [WIDTH-1:0] sum_s;
    logic signed [WIDTH-1:0] diff_s;
    logic [WIDTH-1:0]        alu_res;
    logic                    alu_ovf;
    logic [WIDTH-1:0]        acc_step;
    logic                    accept;
    logic                    mul_last;

    function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b,
                                     input logic signed [WIDTH-1:0] s);
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b,
                                     input logic signed [WIDTH-1:0] d);
        return (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
    endfunction

    assign a_s    = src1_i;
    assign b_s    = src2_i;
    assign sum_s  = a_s + b_s;
    assign diff_s = a_s - b_s;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (ctrl_i)
            OP_AND: alu_res = src1_i & src2_i;
            OP_OR:  alu_res = src1_i | src2_i;
            OP_NOR: alu_res = ~(src1_i | src2_i);
            OP_ADD: begin
                alu_res = sum_s;
                alu_ovf = add_ovf(a_s, b_s, sum_s);
            end
            OP_SUB: begin
                alu_res = diff_s;
                alu_ovf = sub_ovf(a_s, b_s, diff_s);
            end
            // Sign corrected by overflow gives a true signed compare
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}},
                               diff_s[WIDTH-1] ^ sub_ovf(a_s, b_s, diff_s)};
            default: begin
                alu_res = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

    assign accept   = start_i && (state_q == S_IDLE);
    assign mul_last = (state_q == S_MUL) && (cnt_q == CNT_W'(1));
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept && (ctrl_i == OP_MUL)) state_d = S_MUL;
            S_MUL:  if (mul_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Datapath: single-cycle results at the accept edge, one multiply step per MUL edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q == S_IDLE) begin
                if (start_i) begin
                    if (ctrl_i == OP_MUL) begin
                        mcand_q  <= src1_i;
                        mplier_q <= src2_i;
                        acc_q    <= '0;
                        cnt_q    <= CNT_W'(WIDTH);
                    end else begin
                        result_q <= alu_res;
                        zero_q   <= (alu_res == '0);
                        ovf_q    <= alu_ovf;
                        done_q   <= 1'b1;
                    end
                end
            end else begin
                acc_q    <= acc_step;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q - CNT_W'(1);
                if (mul_last) begin
                    result_q <= acc_step;
                    zero_q   <= (acc_step == '0);
                    ovf_q    <= 1'b0;
                    done_q   <= 1'b1;
                end
            end
        end
    end

    assign busy_o     = (state_q == S_MUL);
    assign done_o     = done_q;
    assign result_o   = result_q;
    assign zero_o     = zero_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed testbench for alu_seq_exec: single-cycle ops, multiply timing,
// reset during multiply and back-to-back issue.
module tb_alu_seq_exec;

    localparam int WIDTH = 32;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             start_i = 1'b0;
    logic [3:0]       ctrl_i = 4'b0000;
    logic [WIDTH-1:0] src1_i = '0;
    logic [WIDTH-1:0] src2_i = '0;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             overflow_o;

    int checks = 0;
    int failures = 0;

    alu_seq_exec #(.WIDTH(WIDTH)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .start_i(start_i),
        .ctrl_i(ctrl_i),
        .src1_i(src1_i),
        .src2_i(src2_i),
        .busy_o(busy_o),
        .done_o(done_o),
        .result_o(result_o),
        .zero_o(zero_o),
        .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic test_reset();
        rst_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({busy_o, done_o, zero_o, overflow_o} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got busy/done/zero/ovf=%b want 0000",
                     {busy_o, done_o, zero_o, overflow_o});
        end
        checks++;
        if (result_o !== '0) begin
            failures++;
            $display("FAIL reset_result got %h want 0", result_o);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_single_cycle();
        logic [3:0]       v_ctrl [9];
        logic [WIDTH-1:0] v_a    [9];
        logic [WIDTH-1:0] v_b    [9];
        logic [WIDTH-1:0] v_res  [9];
        logic             v_ovf  [9];
        v_ctrl[0] = 4'b0010; v_a[0] = 32'd7;        v_b[0] = 32'd5;        v_res[0] = 32'd12;       v_ovf[0] = 1'b0;
        v_ctrl[1] = 4'b0110; v_a[1] = 32'h80000000; v_b[1] = 32'd1;        v_res[1] = 32'h7FFFFFFF; v_ovf[1] = 1'b1;
        v_ctrl[2] = 4'b0010; v_a[2] = 32'h7FFFFFFF; v_b[2] = 32'd1;        v_res[2] = 32'h80000000; v_ovf[2] = 1'b1;
        v_ctrl[3] = 4'b0010; v_a[3] = 32'hFFFFFFFF; v_b[3] = 32'd1;        v_res[3] = 32'h00000000; v_ovf[3] = 1'b0;
        v_ctrl[4] = 4'b0111; v_a[4] = 32'hFFFFFFFF; v_b[4] = 32'd1;        v_res[4] = 32'd1;        v_ovf[4] = 1'b0;
        v_ctrl[5] = 4'b0111; v_a[5] = 32'd1;        v_b[5] = 32'hFFFFFFFF; v_res[5] = 32'd0;        v_ovf[5] = 1'b0;
        v_ctrl[6] = 4'b0111; v_a[6] = 32'h80000000; v_b[6] = 32'd1;        v_res[6] = 32'd1;        v_ovf[6] = 1'b0;
        v_ctrl[7] = 4'b0011; v_a[7] = 32'h12345678; v_b[7] = 32'h9ABCDEF0; v_res[7] = 32'd0;        v_ovf[7] = 1'b0;
        v_ctrl[8] = 4'b0110; v_a[8] = 32'd3;        v_b[8] = 32'd5;        v_res[8] = 32'hFFFFFFFE; v_ovf[8] = 1'b0;
        for (int i = 0; i < 9; i++) begin
            start_i = 1'b1; ctrl_i = v_ctrl[i]; src1_i = v_a[i]; src2_i = v_b[i];
            @(negedge clk_i);
            start_i = 1'b0;
            checks++;
            if (done_o !== 1'b1 || result_o !== v_res[i]) begin
                failures++;
                $display("FAIL single_%0d got done=%b res=%h want done=1 res=%h",
                         i, done_o, result_o, v_res[i]);
            end
            checks++;
            if (zero_o !== (v_res[i] == '0) || overflow_o !== v_ovf[i]) begin
                failures++;
                $display("FAIL single_flags_%0d got zero=%b ovf=%b want zero=%b ovf=%b",
                         i, zero_o, overflow_o, (v_res[i] == '0), v_ovf[i]);
            end
            @(negedge clk_i);
            checks++;
            if (done_o !== 1'b0 || result_o !== v_res[i]) begin
                failures++;
                $display("FAIL hold_%0d got done=%b res=%h want done=0 res=%h",
                         i, done_o, result_o, v_res[i]);
            end
        end
    endtask

    task automatic test_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [WIDTH-1:0] exp, input logic prev_ovf_kick);
        int busy_cnt;
        int bad_done;
        logic [WIDTH-1:0] prior;
        prior = result_o;
        busy_cnt = 0;
        bad_done = 0;
        start_i = 1'b1; ctrl_i = 4'b1000; src1_i = a; src2_i = b;
        @(negedge clk_i);
        start_i = 1'b0;
        src1_i = '0; src2_i = '0;
        for (int k = 1; k <= 32; k++) begin
            if (busy_o === 1'b1) busy_cnt++;
            if (done_o !== 1'b0 || result_o !== prior) bad_done++;
            if (prev_ovf_kick && k == 5) begin
                start_i = 1'b1; ctrl_i = 4'b0000;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk_i);
        end
        checks++;
        if (busy_cnt != 32 || bad_done != 0) begin
            failures++;
            $display("FAIL mul_busy got busy_cycles=%0d early_done_or_change=%0d want 32/0",
                     busy_cnt, bad_done);
        end
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || result_o !== exp) begin
            failures++;
            $display("FAIL mul_done got done=%b busy=%b res=%h want done=1 busy=0 res=%h",
                     done_o, busy_o, result_o, exp);
        end
        checks++;
        if (overflow_o !== 1'b0 || zero_o !== (exp == '0)) begin
            failures++;
            $display("FAIL mul_flags got zero=%b ovf=%b want zero=%b ovf=0",
                     zero_o, overflow_o, (exp == '0));
        end
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b0 || result_o !== exp) begin
            failures++;
            $display("FAIL mul_after got done=%b res=%h want done=0 res=%h",
                     done_o, result_o, exp);
        end
    endtask

    task automatic test_reset_mid_mul();
        int stray;
        stray = 0;
        start_i = 1'b1; ctrl_i = 4'b1000; src1_i = 32'd1234; src2_i = 32'd5678;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== '0) begin
            failures++;
            $display("FAIL reset_mid_mul got busy=%b done=%b res=%h want 0 0 0",
                     busy_o, done_o, result_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            if (done_o !== 1'b0 || busy_o !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL reset_abandon got stray_cycles=%0d want 0", stray);
        end
        start_i = 1'b1; ctrl_i = 4'b0010; src1_i = 32'd1; src2_i = 32'd1;
        @(negedge clk_i);
        start_i = 1'b0;
        checks++;
        if (done_o !== 1'b1 || result_o !== 32'd2) begin
            failures++;
            $display("FAIL reset_then_add got done=%b res=%h want done=1 res=2",
                     done_o, result_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_back_to_back();
        logic [3:0]       ops  [4];
        logic [WIDTH-1:0] exps [4];
        ops[0] = 4'b0000; exps[0] = 32'h00F000F0;
        ops[1] = 4'b0001; exps[1] = 32'hFFF0FFF0;
        ops[2] = 4'b1100; exps[2] = 32'h000F000F;
        ops[3] = 4'b0110; exps[3] = 32'hE100E100;
        src1_i = 32'hF0F0F0F0; src2_i = 32'h0FF00FF0;
        for (int i = 0; i < 4; i++) begin
            start_i = 1'b1; ctrl_i = ops[i];
            @(negedge clk_i);
            checks++;
            if (done_o !== 1'b1 || result_o !== exps[i] || overflow_o !== 1'b0) begin
                failures++;
                $display("FAIL b2b_%0d got done=%b res=%h ovf=%b want done=1 res=%h ovf=0",
                         i, done_o, result_o, overflow_o, exps[i]);
            end
        end
        start_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end got done=%b want 0", done_o);
        end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_mul(32'd1234, 32'd5678, 32'd7006652, 1'b1);
        test_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1'b0);
        test_mul(32'd0, 32'hDEADBEEF, 32'd0, 1'b0);
        test_reset_mid_mul();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
